// File: rtl/catch_sound_pkg.sv
// catch_sound_pkg
// Shared definitions for the catch-game audio cue generator: the cue
// sequencer state encoding, the default note/divider/amplitude constants
// and a small helper used to size the oscillator divider counter.
package catch_sound_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NOTE1 = 2'd1,
        GAP   = 2'd2,
        NOTE2 = 2'd3
    } cue_state_e;

    localparam int               DEF_NOTE_LEN   = 27000;
    localparam int               DEF_CATCH_DIV1 = 30;
    localparam int               DEF_CATCH_DIV2 = 20;
    localparam int               DEF_THROW_DIV  = 60;
    localparam logic signed [7:0] DEF_AMPLITUDE = 8'sd64;

    // Largest of three divider settings; sizes the half-period counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/catch_sound_if.sv
// catch_sound_if
// Event/strobe/sample bundle between the ball state machine, the codec
// path and the cue generator.
//   catch_event, throw_event : cue triggers (rising edge starts a cue)
//   ready                    : one-cycle codec sample strobe
//   pcm                      : signed 8-bit sample to the codec
//   busy                     : high while a cue is playing
// master drives the triggers and strobe; slave (the generator) drives
// pcm and busy.
interface catch_sound_if;
    logic              catch_event;
    logic              throw_event;
    logic              ready;
    logic signed [7:0] pcm;
    logic              busy;

    modport master (
        output catch_event,
        output throw_event,
        output ready,
        input  pcm,
        input  busy
    );

    modport slave (
        input  catch_event,
        input  throw_event,
        input  ready,
        output pcm,
        output busy
    );
endinterface

// File: rtl/catch_sound_square_osc.sv
// square_osc
// Square-wave phase generator. A half-period counter runs 0..div-1 while
// enabled and flips phase on every wrap, so one full period is 2*div
// cycles.
//   vclock  : clock
//   reset   : asynchronous active-high reset
//   restart : clear counter and phase (note start); wins over enable
//   enable  : advance the counter this cycle
//   div     : half-period length in clocks
//   phase   : current half of the square wave (0 = negative half)
module square_osc #(
    parameter int DIV_W = 6
) (
    input  logic             vclock,
    input  logic             reset,
    input  logic             restart,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             phase
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [DIV_W:0]   cnt_inc;

    // One extra bit on the increment so the wrap test cannot overflow
    // even when div is the counter's maximum value.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (enable) begin
            if (cnt_inc >= {1'b0, div}) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_inc[DIV_W-1:0];
            end
        end
    end

    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/catch_sound.sv
// catch_sound
// Audio cue generator for the catch game. A rising edge on catch_event
// plays a two-note rising chirp (NOTE1, GAP, NOTE2); a rising edge on
// throw_event plays a single low note. Any new rise restarts the cue.
// The sample register updates only on the codec ready strobe.
//   vclock : 27 MHz system clock
//   reset  : asynchronous active-high reset, clears all state
//   bus    : catch_sound_if.slave (catch_event, throw_event, ready in;
//            pcm, busy out)
// Optional build macro CATCH_SOUND_DECAY_EN: amplitude halves on each
// quarter of a note (AMPLITUDE >>> 0,1,2,3); without it the amplitude is
// constant for the whole note.
module catch_sound
    import catch_sound_pkg::*;
#(
    parameter int                NOTE_LEN   = DEF_NOTE_LEN,
    parameter int                CATCH_DIV1 = DEF_CATCH_DIV1,
    parameter int                CATCH_DIV2 = DEF_CATCH_DIV2,
    parameter int                THROW_DIV  = DEF_THROW_DIV,
    parameter logic signed [7:0] AMPLITUDE  = DEF_AMPLITUDE
) (
    input  logic          vclock,
    input  logic          reset,
    catch_sound_if.slave  bus
);

    localparam int DUR_W   = $clog2(NOTE_LEN) + 1;
    localparam int DIV_MAX = max3(CATCH_DIV1, CATCH_DIV2, THROW_DIV);
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_LEN - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(NOTE_LEN / 4 - 1);
    localparam logic [DIV_W-1:0] DIV1_C    = DIV_W'(CATCH_DIV1);
    localparam logic [DIV_W-1:0] DIV2_C    = DIV_W'(CATCH_DIV2);
    localparam logic [DIV_W-1:0] THROW_C   = DIV_W'(THROW_DIV);

    logic              catch_cur_q, catch_cur_d, catch_prev_q, catch_prev_d;
    logic              throw_cur_q, throw_cur_d, throw_prev_q, throw_prev_d;
    logic              primed_q, primed_d;
    cue_state_e        state_q, state_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              second_q, second_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic signed [7:0] pcm_q, pcm_d;
    logic              busy_q, busy_d;

    logic              catch_rise, throw_rise;
    logic              note_start, tone_on, phase;
    logic signed [7:0] amp, target;

    // Edge detect. For the first cycle after reset both stages load the
    // raw level, so a line already held high cannot look like a rise.
    always_comb begin
        catch_cur_d  = bus.catch_event;
        throw_cur_d  = bus.throw_event;
        catch_prev_d = primed_q ? catch_cur_q : bus.catch_event;
        throw_prev_d = primed_q ? throw_cur_q : bus.throw_event;
        primed_d     = 1'b1;
        catch_rise   = catch_cur_q & ~catch_prev_q;
        throw_rise   = throw_cur_q & ~throw_prev_q;
    end

    // Cue sequencer. A rise in any state restarts NOTE1 with the new cue
    // (catch has priority). dur_q counts cycles within the current state.
    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        second_d   = second_q;
        div_d      = div_q;
        note_start = 1'b0;
        if (catch_rise) begin
            state_d    = NOTE1;
            div_d      = DIV1_C;
            second_d   = 1'b1;
            dur_d      = '0;
            note_start = 1'b1;
        end else if (throw_rise) begin
            state_d    = NOTE1;
            div_d      = THROW_C;
            second_d   = 1'b0;
            dur_d      = '0;
            note_start = 1'b1;
        end else begin
            case (state_q)
                IDLE: dur_d = '0;
                NOTE1: begin
                    if (dur_q == NOTE_LAST) begin
                        dur_d   = '0;
                        state_d = second_q ? GAP : IDLE;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                GAP: begin
                    if (dur_q == GAP_LAST) begin
                        dur_d      = '0;
                        state_d    = NOTE2;
                        div_d      = DIV2_C;
                        note_start = 1'b1;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                NOTE2: begin
                    if (dur_q == NOTE_LAST) begin
                        dur_d   = '0;
                        state_d = IDLE;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
                default: begin
                    dur_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign tone_on = (state_q == NOTE1) || (state_q == NOTE2);

    square_osc #(
        .DIV_W (DIV_W)
    ) u_osc (
        .vclock  (vclock),
        .reset   (reset),
        .restart (note_start),
        .enable  (tone_on),
        .div     (div_q),
        .phase   (phase)
    );

`ifdef CATCH_SOUND_DECAY_EN
    localparam logic [DUR_W-1:0] Q1 = DUR_W'(NOTE_LEN / 4);
    localparam logic [DUR_W-1:0] Q2 = DUR_W'(2 * (NOTE_LEN / 4));
    localparam logic [DUR_W-1:0] Q3 = DUR_W'(3 * (NOTE_LEN / 4));

    // Halve the amplitude each quarter of the note; dur_q restarts at
    // every note start so the decay does too.
    always_comb begin
        if (dur_q >= Q3) begin
            amp = AMPLITUDE >>> 3;
        end else if (dur_q >= Q2) begin
            amp = AMPLITUDE >>> 2;
        end else if (dur_q >= Q1) begin
            amp = AMPLITUDE >>> 1;
        end else begin
            amp = AMPLITUDE;
        end
    end
`else
    assign amp = AMPLITUDE;
`endif

    // Target sample and output registers; pcm follows the target only on
    // codec strobes, busy tracks the registered state.
    always_comb begin
        target = 8'sd0;
        if (tone_on) begin
            target = phase ? amp : -amp;
        end
        pcm_d  = bus.ready ? target : pcm_q;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            catch_cur_q  <= 1'b0;
            catch_prev_q <= 1'b0;
            throw_cur_q  <= 1'b0;
            throw_prev_q <= 1'b0;
            primed_q     <= 1'b0;
            state_q      <= IDLE;
            dur_q        <= '0;
            second_q     <= 1'b0;
            div_q        <= '0;
            pcm_q        <= 8'sd0;
            busy_q       <= 1'b0;
        end else begin
            catch_cur_q  <= catch_cur_d;
            catch_prev_q <= catch_prev_d;
            throw_cur_q  <= throw_cur_d;
            throw_prev_q <= throw_prev_d;
            primed_q     <= primed_d;
            state_q      <= state_d;
            dur_q        <= dur_d;
            second_q     <= second_d;
            div_q        <= div_d;
            pcm_q        <= pcm_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.pcm  = pcm_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_catch_sound.sv
// tb_catch_sound
// Directed bench for catch_sound with NOTE_LEN=40, dividers 3/2/5 and
// amplitude 64. Inputs are driven and outputs sampled on the falling edge.
// Expected samples come from a per-scenario timeline of the cue (note
// start edge, note/gap lengths, divider) plus a model of the ready-gated
// sample register.
module tb_catch_sound;

    logic vclock = 1'b0;
    logic reset  = 1'b1;

    always #5 vclock = ~vclock;

    catch_sound_if bus ();

    catch_sound #(
        .NOTE_LEN   (40),
        .CATCH_DIV1 (3),
        .CATCH_DIV2 (2),
        .THROW_DIV  (5),
        .AMPLITUDE  (8'sd64)
    ) dut (
        .vclock (vclock),
        .reset  (reset),
        .bus    (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Magnitude at cycle rel of a note.
    function automatic int ampAt(input int rel);
`ifdef CATCH_SOUND_DECAY_EN
        return 64 >> (rel / 10);
`else
        return 64;
`endif
    endfunction

    // Square tone: negative for the first div cycles, then alternating.
    function automatic int tone(input int rel, input int div);
        return (((rel / div) % 2) == 1) ? ampAt(rel) : -ampAt(rel);
    endfunction

    // Catch cue: 40 cycles div 3, 10 silent, 40 cycles div 2.
    function automatic int catchTgt(input int rel);
        if (rel < 0)  return 0;
        if (rel < 40) return tone(rel, 3);
        if (rel < 50) return 0;
        if (rel < 90) return tone(rel - 50, 2);
        return 0;
    endfunction

    function automatic int throwTgt(input int rel);
        if (rel < 0 || rel >= 40) return 0;
        return tone(rel, 5);
    endfunction

    // Target sample in the cycle after edge c of a scenario. A rise driven
    // before edge 0 puts NOTE1 in place after edge 1. Scenario 3 adds a
    // throw before edge 25, so its note starts after edge 26.
    function automatic int tgtFor(input int scen, input int c);
        case (scen)
            1:       return throwTgt(c - 1);
            3:       return (c < 26) ? catchTgt(c - 1) : throwTgt(c - 26);
            default: return catchTgt(c - 1);
        endcase
    endfunction

    function automatic int busyFor(input int scen, input int c);
        case (scen)
            1:       return (c >= 1 && c <= 40) ? 1 : 0;
            3:       return (c >= 1 && c <= 65) ? 1 : 0;
            default: return (c >= 1 && c <= 90) ? 1 : 0;
        endcase
    endfunction

    // Scenarios: 0 catch, 1 throw, 2 catch+throw together, 3 catch then
    // throw 25 cycles later, 4 catch with ready every 8th cycle.
    task automatic applyStimulus(input int scen);
        int pcmExp;
        pcmExp = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge vclock);
            checkOutput($sformatf("s%0d_k%0d_pcm", scen, k), int'(bus.pcm), pcmExp);
            checkOutput($sformatf("s%0d_k%0d_busy", scen, k), int'(bus.busy), busyFor(scen, k - 1));
            bus.catch_event = (k == 0) && (scen != 1);
            bus.throw_event = ((k == 0) && (scen == 1 || scen == 2)) || ((k == 25) && (scen == 3));
            bus.ready       = (scen == 4) ? ((k % 8) == 0) : 1'b1;
            if (bus.ready) begin
                pcmExp = tgtFor(scen, k - 1);
            end
        end
    endtask

    initial begin
        bus.catch_event = 1'b1;
        bus.throw_event = 1'b0;
        bus.ready       = 1'b1;
        reset           = 1'b1;

        repeat (3) @(negedge vclock);
        checkOutput("reset_pcm", int'(bus.pcm), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);

        // catch_event held high across reset release: must stay idle.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge vclock);
            checkOutput($sformatf("held_k%0d_busy", i), int'(bus.busy), 0);
            checkOutput($sformatf("held_k%0d_pcm", i), int'(bus.pcm), 0);
        end
        bus.catch_event = 1'b0;
        repeat (3) @(negedge vclock);

        for (int s = 0; s < 5; s++) begin
            $display("[TB] scenario %0d", s);
            applyStimulus(s);
        end

        // Reset in the middle of a cue clears outputs without a clock edge.
        @(negedge vclock);
        bus.ready       = 1'b1;
        bus.catch_event = 1'b1;
        @(negedge vclock);
        bus.catch_event = 1'b0;
        repeat (20) @(negedge vclock);
        checkOutput("midcue_busy_before", int'(bus.busy), 1);
        bus.catch_event = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("midcue_async_pcm", int'(bus.pcm), 0);
        checkOutput("midcue_async_busy", int'(bus.busy), 0);
        repeat (2) @(negedge vclock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge vclock);
            checkOutput($sformatf("post_k%0d_busy", i), int'(bus.busy), 0);
            checkOutput($sformatf("post_k%0d_pcm", i), int'(bus.pcm), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
